// File: rtl/accel_msg_scheduler_if.sv
// Handshake/bus bundle between the message-schedule stage and its host/compressor.
interface accel_msg_scheduler_if;
  logic         start;
  logic         abort;
  logic         adv;
  logic [511:0] blk_in;
  logic [31:0]  w;
  logic [6:0]   i;
  logic         w_valid;
  logic         busy;
  logic         done;

  modport master (
    output start, abort, adv, blk_in,
    input  w, i, w_valid, busy, done
  );

  modport slave (
    input  start, abort, adv, blk_in,
    output w, i, w_valid, busy, done
  );
endinterface

// File: rtl/accel_msg_scheduler.sv
// SHA-256 message schedule: emits W[0..63] from a 16-word sliding window.
// ACCEL_MSG_SCHED_BSWAP_EN: byte-reverse each 32-bit word of blk_in at load.
module accel_msg_scheduler #(
  parameter int unsigned ROUNDS = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  accel_msg_scheduler_if.slave  bus
);
  localparam int unsigned WORD_W = 32;
  localparam int unsigned WORDS  = 16;
  localparam int unsigned IDX_W  = 7;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  state_e                         state_q, state_d;
  logic [WORDS-1:0][WORD_W-1:0]   win_q, win_d;
  logic [WORD_W-1:0]              w_q, w_d;
  logic [IDX_W-1:0]               i_q, i_d;
  logic                           w_valid_q, w_valid_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic [WORD_W-1:0]              w_new;

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Word k of the incoming block, M[0] in the top 32 bits.
  function automatic logic [WORD_W-1:0] load_word(input logic [511:0] blk,
                                                   input int unsigned k);
    logic [WORD_W-1:0] wd;
    wd = blk[WORD_W*(WORDS-1-k) +: WORD_W];
`ifdef ACCEL_MSG_SCHED_BSWAP_EN
    return {wd[7:0], wd[15:8], wd[23:16], wd[31:24]};
`else
    return wd;
`endif
  endfunction

  // W[t] for t = i+16 while win[0] holds W[i].
  assign w_new = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    w_d       = w_q;
    i_d       = i_q;
    w_valid_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d = ST_RUN;
          for (int unsigned k = 0; k < WORDS; k++) win_d[k] = load_word(bus.blk_in, k);
          w_d = load_word(bus.blk_in, 0);
          i_d = '0;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
          w_d     = '0;
          i_d     = '0;
        end else if (bus.adv) begin
          if (i_q == LAST_IDX) begin
            state_d = ST_DONE;
            w_d     = '0;
            i_d     = '0;
          end else begin
            for (int unsigned k = 0; k < WORDS - 1; k++) win_d[k] = win_q[k+1];
            win_d[WORDS-1] = w_new;
            w_d            = win_q[1];
            i_d            = i_q + IDX_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        w_d     = '0;
        i_d     = '0;
      end
      default: begin
        state_d = ST_IDLE;
        w_d     = '0;
        i_d     = '0;
      end
    endcase

    // Status outputs are registered copies of the next state.
    w_valid_d = (state_d == ST_RUN);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      win_q     <= '0;
      w_q       <= '0;
      i_q       <= '0;
      w_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      w_q       <= w_d;
      i_q       <= i_d;
      w_valid_q <= w_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.w       = w_q;
  assign bus.i       = i_q;
  assign bus.w_valid = w_valid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule
